// File: rtl/dmem_stage_cache.sv
// dmem_stage_cache: direct-mapped write-back/write-allocate MEM-stage data cache with line refill/evict.
// Define DCACHE_STATS_EN to add the hit_cnt_o/miss_cnt_o statistics counters.
module dmem_stage_cache #(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wrdata_i,
    output logic [31:0]          rddata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
`ifdef DCACHE_STATS_EN
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
`endif
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);
    localparam int IDX = $clog2(LINES);
    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam int WB  = OFF - 2;
    localparam int TW  = 32 - OFF - IDX;

    typedef enum logic [1:0] {IDLE, EVICT, REFILL} state_t;
    state_t state_q;

    logic [LINE_BITS-1:0] data_q [LINES];
    logic [TW-1:0]        tag_q  [LINES];
    logic [LINES-1:0]     valid_q, dirty_q;
    logic [TW-1:0]        tag;
    logic [IDX-1:0]       idx;
    logic [WB-1:0]        word;
    logic                 access, hit, fill, store, miss, unused;

    assign tag      = addr_i[31 -: TW];
    assign idx      = addr_i[OFF +: IDX];
    assign word     = addr_i[2 +: WB];
    assign unused   = ^addr_i[1:0];
    assign access   = MemRead_i | MemWrite_i;
    assign hit      = valid_q[idx] && tag_q[idx] == tag;
    assign fill     = state_q == REFILL && mem_ack_i;
    assign store    = state_q == IDLE && MemWrite_i && hit;
    assign miss     = state_q == IDLE && access && !hit;
    assign stall_o  = state_q != IDLE || (access && !hit);
    assign rddata_o = MemRead_i && hit ? data_q[idx][{word, 5'd0} +: 32] : '0;

    // Data and tag arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (rst_i && fill) begin
            data_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= tag;
        end else if (rst_i && store) begin
            data_q[idx][{word, 5'd0} +: 32] <= wrdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (miss) begin
                        mem_req_o <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= EVICT;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {tag_q[idx], idx, {OFF{1'b0}}};
                            mem_wdata_o <= data_q[idx];
                        end else begin
                            state_q    <= REFILL;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {tag, idx, {OFF{1'b0}}};
                        end
                    end
                end
                EVICT: begin
                    if (mem_ack_i) begin
                        state_q    <= REFILL;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, {OFF{1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_q      <= IDLE;
                        mem_req_o    <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic refill_done;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            refill_done <= 1'b0;
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
        end else begin
            refill_done <= fill;
            miss_cnt_o  <= miss_cnt_o + {31'd0, miss};
            hit_cnt_o   <= hit_cnt_o + {31'd0, state_q == IDLE && access && hit && !refill_done};
        end
    end
`endif
endmodule

// File: tb/tb_dmem_stage_cache.sv
// tb_dmem_stage_cache: directed bench for dmem_stage_cache with a memory responder and load-data scoreboard.
// Stats counters are checked when DCACHE_STATS_EN is defined.
module tb_dmem_stage_cache;
    logic         clk_i = 1'b0;
    logic         rst_i, MemRead_i, MemWrite_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  addr_i, wrdata_i, rddata_o, mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif
    int           errors = 0;
    int           checks = 0;
    logic [31:0]  sb [$];
    logic [255:0] line1, line2, line3, ev;

    dmem_stage_cache dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wrdata_i(wrdata_i), .rddata_o(rddata_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag);
        int n;
        n = sb.size();
        check({tag, "_sb_nonempty"}, n != 0, 1'b1);
        if (n != 0) check(tag, rddata_o, sb.pop_front());
    endtask

    task automatic serve(input int hold, input logic we, input logic [31:0] a,
                         input logic [255:0] wd, input logic [255:0] rd);
        int n;
        n = 0;
        while (!mem_req_o && n < 50) begin
            tick;
            n++;
        end
        check("mem_req", mem_req_o, 1'b1);
        check("mem_we", mem_we_o, we);
        check("mem_addr", mem_addr_o, a);
        if (we) check("mem_wdata", mem_wdata_o, wd);
        for (int i = 0; i < hold; i++) begin
            tick;
            check("hold_stable", {mem_req_o, mem_we_o, stall_o, mem_addr_o}, {1'b1, we, 1'b1, a});
        end
        mem_rdata_i = rd;
        mem_ack_i   = 1'b1;
        tick;
        mem_ack_i   = 1'b0;
    endtask

    initial begin
        line1 = '0; line1[31:0] = 32'hDEAD_BEEF; line1[63:32] = 32'hCAFE_0001; line1[95:64] = 32'h2222_0002;
        line2 = '0; line2[31:0] = 32'h0440_0000; line2[95:64] = 32'h0440_0002; line2[255:224] = 32'h0440_0007;
        line3 = '0; line3[31:0] = 32'h3333_0000;
        ev = line1; ev[63:32] = 32'h1234_5678;
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = '0; wrdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick;
        tick;
        rst_i = 1'b1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_rddata", rddata_o, 32'h0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        // clean miss and refill
        MemRead_i = 1'b1; addr_i = 32'h40; sb.push_back(32'hDEAD_BEEF);
        #1 check("miss_stall", stall_o, 1'b1);
        serve(0, 1'b0, 32'h40, '0, line1);
        check("refill_stall_drop", stall_o, 1'b0);
        check("refill_req_drop", mem_req_o, 1'b0);
        expect_rd("load_40");
        tick;
        // store hit then load back
        MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h44; wrdata_i = 32'h1234_5678;
        #1 check("store_stall", stall_o, 1'b0);
        check("store_rddata", rddata_o, 32'h0);
        tick;
        MemRead_i = 1'b1; MemWrite_i = 1'b0; sb.push_back(32'h1234_5678);
        #1 check("load44_stall", stall_o, 1'b0);
        expect_rd("load_44");
        tick;
        check("load44_no_req", mem_req_o, 1'b0);
        // dirty conflict miss: evict then refill with a 10-cycle ack delay
        addr_i = 32'h440; sb.push_back(32'h0440_0000);
        #1 check("conflict_stall", stall_o, 1'b1);
        serve(0, 1'b1, 32'h40, ev, '0);
        serve(10, 1'b0, 32'h440, '0, line2);
        check("evict_refill_stall_drop", stall_o, 1'b0);
        expect_rd("load_440");
`ifdef DCACHE_STATS_EN
        check("miss_cnt", miss_cnt_o, 32'd2);
        check("hit_cnt", hit_cnt_o, 32'd2);
`endif
        tick;
        // read+write together acts as store, shows old word
        MemWrite_i = 1'b1; addr_i = 32'h448; wrdata_i = 32'hAAAA_5555; sb.push_back(32'h0440_0002);
        #1 expect_rd("rw_old_word");
        tick;
        MemWrite_i = 1'b0; sb.push_back(32'hAAAA_5555);
        #1 expect_rd("rw_new_word");
        addr_i = 32'h45C; sb.push_back(32'h0440_0007);
        #1 expect_rd("load_last_word");
        tick;
        // reset mid-evict
        addr_i = 32'h840;
        tick;
        check("evict2_req", mem_req_o, 1'b1);
        check("evict2_we", mem_we_o, 1'b1);
        check("evict2_addr", mem_addr_o, 32'h440);
        rst_i = 1'b0; MemRead_i = 1'b0;
        tick;
        rst_i = 1'b1;
        check("abort_req", mem_req_o, 1'b0);
        check("abort_stall", stall_o, 1'b0);
        check("abort_addr", mem_addr_o, 32'h0);
        mem_ack_i = 1'b1;
        tick;
        mem_ack_i = 1'b0;
        check("late_ack_req", mem_req_o, 1'b0);
        check("late_ack_stall", stall_o, 1'b0);
        MemRead_i = 1'b1; addr_i = 32'h440; sb.push_back(32'h3333_0000);
        #1 check("post_reset_miss", stall_o, 1'b1);
        serve(2, 1'b0, 32'h440, '0, line3);
        check("post_reset_stall_drop", stall_o, 1'b0);
        expect_rd("load_440_again");
        MemRead_i = 1'b0;
        tick;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_stage_cache.md
Name: dmem_stage_cache

Overview:
- Memory-stage data cache that consumes the EX/MEM register outputs (ALU result as address, store data, MemRead/MemWrite).
- Produces the load data for MEM/WB.
- Drives the stall that freezes the EX/MEM register and upstream stages on a miss.
- Direct-mapped, write-back, write-allocate; refills from and evicts to a slow line-wide data memory over a req/ack handshake.

Parameters:
- LINES, 32, number of cache lines; power of two, >= 2.
- LINE_BITS, 256, bits per line (8 words); offset field = log2(LINE_BITS/8) = 5 address bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- addr_i  in  32  byte address (EX/MEM ALU result); bits [1:0] ignored.
- wrdata_i  in  32  store data.
- rddata_o  out  32  load data; valid when MemRead_i=1 and stall_o=0.
- stall_o  out  1  pipeline stall; drives EX/MEM stall_i and upstream freezes.
- mem_req_o  out  1  memory request, level-held until ack.
- mem_we_o  out  1  1 = line write (evict), 0 = line read (refill).
- mem_addr_o  out  32  line-aligned address (low 5 bits zero).
- mem_wdata_o  out  LINE_BITS  evicted line data.
- mem_rdata_i  in  LINE_BITS  refill data; sampled on the ack cycle.
- mem_ack_i  in  1  single-cycle completion pulse from memory.

Behaviour:
Address and lookup:
- Address split: tag = addr_i[31:5+IDX], index = addr_i[5+IDX-1:5] (IDX = log2 LINES), word = addr_i[4:2].
- access = MemRead_i | MemWrite_i.
- hit = valid[index] & (tag_array[index] == tag).

Stall and load data:
- stall_o is combinational: stall_o = (state != IDLE) | (access & ~hit).
- Load hit: rddata_o = selected word, combinational, zero extra latency. rddata_o = 0 when no load hit.

Stores:
- Store hit in IDLE: the word is written at the clock edge and dirty[index] is set.
- MemRead_i and MemWrite_i both 1: treated as a store; rddata_o still shows the pre-store word.

FSM states: IDLE, EVICT, REFILL.
- IDLE, access & miss & dirty victim -> EVICT.
- IDLE, access & miss & clean or invalid victim -> REFILL.
- EVICT: mem_req_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = victim line. On mem_ack_i -> REFILL.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, index, 5'b0}. On mem_ack_i: line <= mem_rdata_i, tag stored, valid=1, dirty=0 -> IDLE.
- Back in IDLE the access is re-evaluated, now hits, and stall_o drops that cycle; a pending store merges then.

Handshake and timing:
- mem_addr_o, mem_we_o and mem_wdata_o are stable while mem_req_o=1.
- mem_req_o deasserts the cycle after ack.
- mem_ack_i while not requesting is ignored.
- Miss latency: clean miss = refill wait + 2 cycles stalled; dirty miss adds the evict wait + 1.
- Inputs must hold stable while stall_o=1; EX/MEM guarantees this.

Reset (rst_i=0 at an edge):
- state=IDLE, all valid=0, all dirty=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-EVICT/REFILL aborts the transaction; any later ack is ignored.
- Data and tag arrays need no reset.
- Outputs at reset: stall_o=0 and rddata_o=0 when no access.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0, wrapping.
  - miss_cnt_o increments once per IDLE->EVICT/REFILL transition.
  - hit_cnt_o increments on an IDLE access hit, except the retry cycle immediately after a REFILL completion (tracked by a 1-bit refill_done flag).
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load addr 0x0000_0040 -> stall_o=1 same cycle; REFILL with mem_addr_o=0x40, mem_we_o=0; ack with line word0=0xDEAD_BEEF -> next cycle stall_o=0, rddata_o=0xDEAD_BEEF.
- Store 0x1234_5678 to 0x44 after that refill -> no stall; subsequent load 0x44 returns 0x1234_5678, no memory request.
- Load 0x0000_0440 (same index 2, different tag) with dirty line -> EVICT with mem_addr_o=0x40, mem_we_o=1, mem_wdata_o word1=0x1234_5678; after ack, REFILL at 0x440; stall drops after second ack.
- Memory holds ack off for 10 cycles in REFILL -> mem_req_o, mem_addr_o and stall_o held constant all 10 cycles; one-cycle ack completes the refill.
- rst_i=0 during EVICT -> next cycle mem_req_o=0, state IDLE; late ack ignored; previously valid address misses again.
- With DCACHE_STATS_EN, run the sequence of scenarios 1-3 -> miss_cnt_o=2, hit_cnt_o=2.
